// File: rtl/sysid_check_pkg.sv
// Shared definitions for the system-ID check controller.
// - state_t       : controller state encoding (3 bits)
// - SYSID_ADDR_*  : word addresses of the ID and timestamp registers
// - timer_width() : width of a counter that can hold a given cycle count
package sysid_check_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ID_REQ  = 3'd1,
    ST_ID_WAIT = 3'd2,
    ST_TS_REQ  = 3'd3,
    ST_TS_WAIT = 3'd4,
    ST_CHECK   = 3'd5,
    ST_FINISH  = 3'd6
  } state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  // log2 of the cycle count plus one, so the counter can always reach the limit
  function automatic int timer_width(input int cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/sysid_check_timer.sv
// Loadable cycle counter used for per-read timeouts (and periodic rechecks).
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   clear          : synchronous return to zero (wins over enable)
//   enable         : count up by one this cycle
//   limit          : value at which the counter reports expiry
//   expired        : count equals limit
module sysid_check_timer
  import sysid_check_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             expired
);

  logic [WIDTH-1:0] count_r;

  // cycle counter: clear has priority over enable
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable) begin
      count_r <= count_r + WIDTH'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == limit);

endmodule

// File: rtl/sysid_check_ctrl.sv
// Avalon-MM read master that reads the system-ID slave (word 0 = ID,
// word 1 = timestamp), compares both against build-time values and
// publishes sticky pass/fail/timeout status.
// Ports:
//   clock, reset_n        : clock, asynchronous active-low reset
//   av_address/av_read    : read request to the system-ID slave
//   av_readdata, av_waitrequest, av_readdatavalid : slave response
//   start                 : single-cycle check request
//   busy, done            : check in progress / one-cycle completion pulse
//   id_ok, ts_ok, timeout_err : sticky result of the last check
//   captured_id, captured_ts  : last words read
// Optional feature: define SYSID_CHECK_PERIODIC_EN to add a free-running
// recheck counter (parameter RECHECK_CYCLES) that requests a check from IDLE.
module sysid_check_ctrl
  import sysid_check_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1427079909,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          USE_RDV        = 0,
  parameter int          AUTO_START     = 1
`ifdef SYSID_CHECK_PERIODIC_EN
  ,
  parameter logic [31:0] RECHECK_CYCLES = 32'd16777216
`endif
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        av_address,
  output logic        av_read,
  input  logic [31:0] av_readdata,
  input  logic        av_waitrequest,
  input  logic        av_readdatavalid,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts
);

  localparam int            TW       = timer_width(TIMEOUT_CYCLES);
  // expiring at LIMIT means the read has used TIMEOUT_CYCLES cycles by the end of this one
  localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES - 1);

  state_t state_r;
  state_t state_s;
  logic   pending_r;
  logic   in_xfer_s;
  logic   cap_id_s;
  logic   cap_ts_s;
  logic   timeout_s;
  logic   tmr_clear_s;
  logic   tmr_expired_s;
  logic   periodic_hit_s;

  assign in_xfer_s = (state_r == ST_ID_REQ) || (state_r == ST_ID_WAIT) ||
                     (state_r == ST_TS_REQ) || (state_r == ST_TS_WAIT);

  // next-state decode, capture strobes and timeout override
  always_comb begin
    state_s   = state_r;
    cap_id_s  = 1'b0;
    cap_ts_s  = 1'b0;
    timeout_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start || pending_r) state_s = ST_ID_REQ;
        else                    state_s = ST_IDLE;
      end
      ST_ID_REQ: begin
        if (!av_waitrequest) begin
          if (USE_RDV != 0) begin
            state_s = ST_ID_WAIT;
          end else begin
            cap_id_s = 1'b1;
            state_s  = ST_TS_REQ;
          end
        end else begin
          state_s = ST_ID_REQ;
        end
      end
      ST_ID_WAIT: begin
        if (av_readdatavalid) begin
          cap_id_s = 1'b1;
          state_s  = ST_TS_REQ;
        end else begin
          state_s = ST_ID_WAIT;
        end
      end
      ST_TS_REQ: begin
        if (!av_waitrequest) begin
          if (USE_RDV != 0) begin
            state_s = ST_TS_WAIT;
          end else begin
            cap_ts_s = 1'b1;
            state_s  = ST_CHECK;
          end
        end else begin
          state_s = ST_TS_REQ;
        end
      end
      ST_TS_WAIT: begin
        if (av_readdatavalid) begin
          cap_ts_s = 1'b1;
          state_s  = ST_CHECK;
        end else begin
          state_s = ST_TS_WAIT;
        end
      end
      ST_CHECK:  state_s = ST_FINISH;
      // a check queued while busy starts straight away so busy stays high
      ST_FINISH: begin
        if (pending_r) state_s = ST_ID_REQ;
        else           state_s = ST_IDLE;
      end
      default:   state_s = ST_IDLE;
    endcase
    // data arriving in the last budgeted cycle still counts; a mere acceptance does not
    if (in_xfer_s && tmr_expired_s && !(cap_id_s || cap_ts_s)) begin
      timeout_s = 1'b1;
      state_s   = ST_FINISH;
    end else begin
      timeout_s = 1'b0;
    end
  end

  // restart the per-read budget outside transfers and when the timestamp read begins
  assign tmr_clear_s = !in_xfer_s || ((state_s == ST_TS_REQ) && (state_r != ST_TS_REQ));

  sysid_check_timer #(.WIDTH(TW)) u_timeout (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (tmr_clear_s),
    .enable  (in_xfer_s),
    .limit   (TO_LIMIT),
    .expired (tmr_expired_s)
  );

`ifdef SYSID_CHECK_PERIODIC_EN
  logic per_expired_s;

  sysid_check_timer #(.WIDTH(32)) u_periodic (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   ((state_r != ST_IDLE) || per_expired_s),
    .enable  (state_r == ST_IDLE),
    .limit   (RECHECK_CYCLES - 32'd1),
    .expired (per_expired_s)
  );

  assign periodic_hit_s = per_expired_s && (state_r == ST_IDLE);
`else
  assign periodic_hit_s = 1'b0;
`endif

  // state, bus outputs, captures, sticky status and pending request
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      pending_r   <= (AUTO_START != 0) ? 1'b1 : 1'b0;
      av_read     <= 1'b0;
      av_address  <= SYSID_ADDR_ID;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout_err <= 1'b0;
      captured_id <= 32'd0;
      captured_ts <= 32'd0;
    end else begin
      state_r    <= state_s;
      av_read    <= (state_s == ST_ID_REQ) || (state_s == ST_TS_REQ);
      av_address <= ((state_s == ST_TS_REQ) || (state_s == ST_TS_WAIT)) ? SYSID_ADDR_TS
                                                                       : SYSID_ADDR_ID;
      busy       <= (state_s != ST_IDLE);
      done       <= (state_s == ST_FINISH);

      if (cap_id_s) captured_id <= av_readdata;
      else          captured_id <= captured_id;
      if (cap_ts_s) captured_ts <= av_readdata;
      else          captured_ts <= captured_ts;

      if (timeout_s) begin
        timeout_err <= 1'b1;
        id_ok       <= 1'b0;
        ts_ok       <= 1'b0;
      end else if (state_r == ST_CHECK) begin
        timeout_err <= 1'b0;
        id_ok       <= (captured_id == EXPECTED_ID);
        ts_ok       <= (captured_ts == EXPECTED_TS);
      end else begin
        timeout_err <= timeout_err;
        id_ok       <= id_ok;
        ts_ok       <= ts_ok;
      end

      case (state_r)
        ST_IDLE: begin
          if (start || pending_r) pending_r <= 1'b0;
          else if (periodic_hit_s) pending_r <= 1'b1;
          else pending_r <= pending_r;
        end
        // a queued check is consumed here; otherwise a start now queues the next one
        ST_FINISH: begin
          if (pending_r) pending_r <= 1'b0;
          else           pending_r <= start;
        end
        default: begin
          if (start) pending_r <= 1'b1;
          else       pending_r <= pending_r;
        end
      endcase
    end
  end

endmodule
